// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one combinational 8-bit ALU between NUM_REQ requesters.
// One operation in flight at a time; results return over a valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; req_ready grants the round-robin winner combinationally
// EXEC  | op regs drive the ALU; result (or illegal-opcode error) is registered
// RESP  | rsp_valid high, response held until rsp_ready; pointer advances past the winner
module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data1,
  input  logic [8*NUM_REQ-1:0]   req_data2,
  input  logic [3*NUM_REQ-1:0]   req_select,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             alu_data1,
  output logic [7:0]             alu_data2,
  output logic [2:0]             alu_select,
  input  logic [7:0]             alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [7:0]             rsp_result,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int IDW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [7:0]       op_data1;
  logic [7:0]       op_data2;
  logic [2:0]       op_sel;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_id;
  logic               found;
  int                 cand;
  logic [7:0]         sel_data1;
  logic [7:0]         sel_data2;
  logic [2:0]         sel_op;

  // Round-robin search starting at ptr; only meaningful (and only exposed) in IDLE.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = 0;
    if (state == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && (i == cand) && req_valid[i]) begin
            grant[i] = 1'b1;
            gnt_id   = IDW'(i);
            found    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_data1 = '0;
    sel_data2 = '0;
    sel_op    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data1 = req_data1[8*i +: 8];
        sel_data2 = req_data2[8*i +: 8];
        sel_op    = req_select[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (found) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Opcodes 100..111 are illegal: the ALU output is ignored and an error is returned instead.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr        <= '0;
      win        <= '0;
      op_data1   <= '0;
      op_data2   <= '0;
      op_sel     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_data1 <= sel_data1;
            op_data2 <= sel_data2;
            op_sel   <= sel_op;
            win      <= gnt_id;
          end
        end
        EXEC: begin
          rsp_id <= win;
          if (op_sel[2]) begin
            rsp_result <= 8'h00;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (win == IDW'(NUM_REQ - 1)) ptr <= '0;
            else                          ptr <= win + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_data1  = op_data1;
  assign alu_data2  = op_data2;
  assign alu_select = op_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table-driven single ops, hand sequences for arbitration/stall/reset,
// then randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int N = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data1;
  logic [8*N-1:0] req_data2;
  logic [3*N-1:0] req_select;
  logic [N-1:0]   req_ready;
  logic [7:0]     alu_data1;
  logic [7:0]     alu_data2;
  logic [2:0]     alu_select;
  logic [7:0]     alu_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_result;
  logic           rsp_err;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_select (req_select),
    .req_ready  (req_ready),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 000 NOT a, 001 ADD, 010 AND, 011 OR; illegal codes return junk the arbiter must discard.
  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] s);
    case (s)
      3'b000:  return ~a;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 8'hA5;
    endcase
  endfunction

  assign alu_result = alu_f(alu_data1, alu_data2, alu_select);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, logic [7:0] d1, logic [7:0] d2, logic [2:0] s);
    req_data1[8*r +: 8]  = d1;
    req_data2[8*r +: 8]  = d2;
    req_select[3*r +: 3] = s;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // One op from requester r alone, rsp_ready high; checks grant, op regs, latency and response.
  task automatic run_op(int r, logic [7:0] d1, logic [7:0] d2, logic [2:0] s,
                        logic [7:0] er, logic ee);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    set_req(r, d1, d2, s);
    rsp_ready = 1'b1;
    #1;
    check("op_grant", 32'(req_ready), 32'(1 << r));
    tick();
    req_valid = '0;
    set_req(r, ~d1, ~d2, ~s);
    #1;
    check("op_exec_busy", 32'(busy), 32'd1);
    check("op_exec_valid", 32'(rsp_valid), 32'd0);
    check("op_alu_d1", 32'(alu_data1), 32'(d1));
    check("op_alu_d2", 32'(alu_data2), 32'(d2));
    check("op_alu_sel", 32'(alu_select), 32'(s));
    tick();
    check("op_rsp_valid", 32'(rsp_valid), 32'd1);
    check("op_rsp_id", 32'(rsp_id), 32'(r));
    check("op_rsp_result", 32'(rsp_result), 32'(er));
    check("op_rsp_err", 32'(rsp_err), 32'(ee));
    tick();
    check("op_done_valid", 32'(rsp_valid), 32'd0);
    check("op_done_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         r;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] s;
    logic [7:0] er;
    logic       ee;
  } vec_t;

  vec_t tbl[8];

  int         ptr_m;
  int         age;
  int         idx;
  int         win_m;
  int         e_id;
  logic [7:0] e_res;
  logic       e_err;
  logic [2:0] e_sel;
  bit         outst;
  bit         was;
  logic [N-1:0] exp_g;

  initial begin
    tbl[0] = '{0, 8'h0F, 8'hF0, 3'b001, 8'hFF, 1'b0};
    tbl[1] = '{0, 8'h0F, 8'hF0, 3'b000, 8'hF0, 1'b0};
    tbl[2] = '{1, 8'h0F, 8'hF0, 3'b010, 8'h00, 1'b0};
    tbl[3] = '{1, 8'h0F, 8'hF0, 3'b011, 8'hFF, 1'b0};
    tbl[4] = '{0, 8'hFF, 8'h02, 3'b001, 8'h01, 1'b0};
    tbl[5] = '{1, 8'h12, 8'h34, 3'b101, 8'h00, 1'b1};
    tbl[6] = '{1, 8'h12, 8'h34, 3'b001, 8'h46, 1'b0};
    tbl[7] = '{0, 8'hAA, 8'h55, 3'b111, 8'h00, 1'b1};

    req_data1  = '0;
    req_data2  = '0;
    req_select = '0;
    do_reset();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_alu", 32'({alu_data1, alu_data2, alu_select}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 8; v++)
      run_op(tbl[v].r, tbl[v].d1, tbl[v].d2, tbl[v].s, tbl[v].er, tbl[v].ee);

    // Both requesters held valid: strict alternation starting at requester 0.
    do_reset();
    set_req(0, 8'h01, 8'h02, 3'b001);
    set_req(1, 8'h10, 8'h20, 3'b001);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("rr_grant", 32'(req_ready), 32'(1 << (k % 2)));
      tick();
      check("rr_exec_ready", 32'(req_ready), 32'd0);
      tick();
      check("rr_id", 32'(rsp_id), 32'(k % 2));
      check("rr_result", 32'(rsp_result), (k % 2 == 0) ? 32'h03 : 32'h30);
      tick();
    end
    req_valid = '0;
    tick();

    // Response stall: everything frozen while rsp_ready is low.
    req_valid = 2'b01;
    set_req(0, 8'h40, 8'h05, 3'b001);
    rsp_ready = 1'b0;
    #1;
    check("stall_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b11;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_result", 32'(rsp_result), 32'h45);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_release_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("stall_next_grant", 32'(req_ready), 32'd2);
    req_valid = '0;
    tick();

    // Reset during EXEC aborts the op and returns the pointer to 0.
    do_reset();
    run_op(0, 8'h01, 8'h01, 3'b001, 8'h02, 1'b0);
    req_valid = 2'b10;
    set_req(1, 8'h33, 8'h11, 3'b010);
    #1;
    check("abort_grant", 32'(req_ready), 32'd2);
    tick();
    req_valid = '0;
    reset_n   = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_alu_sel", 32'(alu_select), 32'd0);
    req_valid = 2'b11;
    #1;
    check("abort_ptr0", 32'(req_ready), 32'd1);
    req_valid = '0;
    #1;
    run_op(1, 8'h33, 8'h11, 3'b010, 8'h11, 1'b0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    ptr_m = 0;
    outst = 1'b0;
    age   = 0;
    e_id  = 0;
    e_res = '0;
    e_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (outst) age++;
      req_valid  = N'($urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req_data1  = (8*N)'($urandom);
      req_data2  = (8*N)'($urandom);
      req_select = (3*N)'($urandom);
      #1;
      was   = outst;
      win_m = -1;
      exp_g = '0;
      if (!was) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr_m + k) % N;
          if (win_m < 0 && req_valid[idx]) win_m = idx;
        end
      end
      if (win_m >= 0) exp_g[win_m] = 1'b1;
      check("rnd_grant", 32'(req_ready), 32'(exp_g));
      check("rnd_valid", 32'(rsp_valid), 32'(was && age >= 2));
      if (was && age >= 2) begin
        check("rnd_id", 32'(rsp_id), 32'(e_id));
        check("rnd_result", 32'(rsp_result), 32'(e_res));
        check("rnd_err", 32'(rsp_err), 32'(e_err));
        if (rsp_ready) begin
          outst = 1'b0;
          ptr_m = (e_id + 1) % N;
        end
      end
      if (win_m >= 0) begin
        outst = 1'b1;
        age   = 0;
        e_id  = win_m;
        e_sel = req_select[3*win_m +: 3];
        e_err = e_sel[2];
        e_res = e_sel[2] ? 8'h00
                         : alu_f(req_data1[8*win_m +: 8], req_data2[8*win_m +: 8], e_sel);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
